// File: rtl/riscv_multicycle_ctrl_if.sv
// Memory handshake between the multicycle sequencer and the unified
// instruction/data memory.
interface riscv_multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output iord,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  iord,
        output mem_ready
    );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Moore-style multicycle sequencer for the RV32 subset datapath with
// memory handshake timeout and retired-instruction counter.
module riscv_multicycle_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    riscv_multicycle_ctrl_if.master m_mem,
    input  logic [6:0]             i_opcode,
    input  logic                   i_zero,
    output logic                   o_ir_write,
    output logic                   o_pc_en,
    output logic                   o_pc_src,
    output logic [1:0]             o_alusrc_a,
    output logic [1:0]             o_alusrc_b,
    output logic [1:0]             o_aluop,
    output logic                   o_reg_write,
    output logic                   o_memtoreg,
    output logic                   o_halted,
    output logic [1:0]             o_err,
    output logic [CNT_W-1:0]       o_instret,
    output logic                   o_retire
);

    localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU,
        S_MEM_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_HALT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WW-1:0]    r_wait;
    logic [1:0]       r_err;
    logic [1:0]       w_err_next;
    logic [CNT_W-1:0] r_instret;
    logic             w_ready;
    logic             w_timeout;
    logic             w_req;
    logic             w_we;
    logic             w_iord;
    logic             w_ir;
    logic             w_pc_en;
    logic             w_rw;
    logic             w_retire;

    assign w_ready   = m_mem.mem_ready;
    assign w_timeout = (TIMEOUT != 0) && !w_ready
                       && (r_wait == WW'(TIMEOUT - 1));

    always_comb begin
        w_next     = r_state;
        w_err_next = r_err;
        w_req      = 1'b0;
        w_we       = 1'b0;
        w_iord     = 1'b0;
        w_ir       = 1'b0;
        w_pc_en    = 1'b0;
        w_rw       = 1'b0;
        w_retire   = 1'b0;
        o_pc_src   = 1'b0;
        o_alusrc_a = 2'd0;
        o_alusrc_b = 2'd0;
        o_aluop    = 2'd0;
        o_memtoreg = 1'b0;
        o_halted   = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                w_req      = 1'b1;
                o_alusrc_b = 2'd1;
                w_ir       = w_ready;
                w_pc_en    = w_ready;
                if (w_ready) begin
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next     = S_HALT;
                    w_err_next = 2'd2;
                end
            end
            S_DECODE: begin
                o_alusrc_a = 2'd1;
                o_alusrc_b = 2'd2;
                unique case (i_opcode)
                    OP_R:         w_next = S_EXEC_R;
                    OP_I:         w_next = S_EXEC_I;
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_BEQ:       w_next = S_BRANCH;
                    default: begin
                        w_next     = S_HALT;
                        w_err_next = 2'd1;
                    end
                endcase
            end
            S_EXEC_R: begin
                o_alusrc_a = 2'd2;
                o_aluop    = 2'd2;
                w_next     = S_WB_ALU;
            end
            S_EXEC_I: begin
                o_alusrc_a = 2'd2;
                o_alusrc_b = 2'd2;
                w_next     = S_WB_ALU;
            end
            S_WB_ALU: begin
                w_rw     = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEM_ADDR: begin
                o_alusrc_a = 2'd2;
                o_alusrc_b = 2'd2;
                w_next     = (i_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_req  = 1'b1;
                w_iord = 1'b1;
                if (w_ready) begin
                    w_next = S_WB_MEM;
                end else if (w_timeout) begin
                    w_next     = S_HALT;
                    w_err_next = 2'd2;
                end
            end
            S_WB_MEM: begin
                w_rw       = 1'b1;
                o_memtoreg = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WR: begin
                w_req    = 1'b1;
                w_we     = 1'b1;
                w_iord   = 1'b1;
                w_retire = w_ready;
                if (w_ready) begin
                    w_next = S_FETCH;
                end else if (w_timeout) begin
                    w_next     = S_HALT;
                    w_err_next = 2'd2;
                end
            end
            S_BRANCH: begin
                o_alusrc_a = 2'd2;
                o_aluop    = 2'd1;
                o_pc_src   = 1'b1;
                w_pc_en    = i_zero;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_HALT: o_halted = 1'b1;
            default: w_next = S_HALT;
        endcase
    end

    // Reset must kill enables combinationally: FETCH decodes mem_req=1.
    assign m_mem.mem_req = w_req & ~rst;
    assign m_mem.mem_we  = w_we;
    assign m_mem.iord    = w_iord;
    assign o_ir_write    = w_ir & ~rst;
    assign o_pc_en       = w_pc_en & ~rst;
    assign o_reg_write   = w_rw & ~rst;
    assign o_retire      = w_retire & ~rst;
    assign o_err         = r_err;
    assign o_instret     = r_instret;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_err     <= 2'd0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err_next;
            if (w_retire)
                r_instret <= r_instret + CNT_W'(1);
            if (w_ready || (w_next != r_state))
                r_wait <= '0;
            else if (w_req)
                r_wait <= r_wait + WW'(1);
        end
    end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench for riscv_multicycle_ctrl: directed instruction
// sequences, halts, timeout and counter wrap.
module tb_riscv_multicycle_ctrl;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef struct {
        int          cyc;
        logic [31:0] cnt;
        logic        pc_en;
        logic        pc_src;
        logic        rw;
        logic        m2r;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    riscv_multicycle_ctrl_if bus_a ();
    riscv_multicycle_ctrl_if bus_b ();
    assign bus_a.mem_ready = mem_ready;
    assign bus_b.mem_ready = mem_ready;

    logic        a_ir, a_pc_en, a_pc_src, a_rw, a_m2r, a_halted, a_retire;
    logic [1:0]  a_srca, a_srcb, a_aluop, a_err;
    logic [31:0] a_instret;
    logic        b_ir, b_pc_en, b_pc_src, b_rw, b_m2r, b_halted, b_retire;
    logic [1:0]  b_srca, b_srcb, b_aluop, b_err;
    logic [3:0]  b_instret;

    riscv_multicycle_ctrl #(.CNT_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .m_mem(bus_a.master),
        .i_opcode(opcode), .i_zero(zero),
        .o_ir_write(a_ir), .o_pc_en(a_pc_en), .o_pc_src(a_pc_src),
        .o_alusrc_a(a_srca), .o_alusrc_b(a_srcb), .o_aluop(a_aluop),
        .o_reg_write(a_rw), .o_memtoreg(a_m2r), .o_halted(a_halted),
        .o_err(a_err), .o_instret(a_instret), .o_retire(a_retire)
    );

    riscv_multicycle_ctrl #(.CNT_W(4), .TIMEOUT(15)) dut4 (
        .clk(clk), .rst(rst), .m_mem(bus_b.master),
        .i_opcode(opcode), .i_zero(zero),
        .o_ir_write(b_ir), .o_pc_en(b_pc_en), .o_pc_src(b_pc_src),
        .o_alusrc_a(b_srca), .o_alusrc_b(b_srcb), .o_aluop(b_aluop),
        .o_reg_write(b_rw), .o_memtoreg(b_m2r), .o_halted(b_halted),
        .o_err(b_err), .o_instret(b_instret), .o_retire(b_retire)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          scyc = 1;
    int          pcnt;
    logic [31:0] exp_cnt = 32'd0;
    exp_t        sbq[$];

    always @(posedge clk or posedge rst)
        if (rst) pcnt <= 0;
        else     pcnt <= pcnt + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each retire pulse pops one expected record.
    always begin
        @(negedge clk);
        #2;
        if (!rst && a_retire) begin
            if (sbq.size() == 0) begin
                check("unexpected_retire", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("retire_cycle", pcnt + 1, e.cyc);
                check("retire_instret", a_instret, e.cnt);
                check("retire_instret4", {28'd0, b_instret},
                      {28'd0, e.cnt[3:0]});
                check("retire_pc_en", {31'd0, a_pc_en}, {31'd0, e.pc_en});
                check("retire_pc_src", {31'd0, a_pc_src}, {31'd0, e.pc_src});
                check("retire_reg_write", {31'd0, a_rw}, {31'd0, e.rw});
                check("retire_memtoreg", {31'd0, a_m2r}, {31'd0, e.m2r});
            end
        end
    end

    task automatic instr(input logic [6:0] op, input logic z,
                         input int fw, input int mw);
        exp_t e;
        int   lat;
        int   n;
        int   rel;
        lat = (op == OP_LW) ? 5 : (op == OP_BEQ) ? 3 : 4;
        n = lat + fw + mw;
        e.cyc    = scyc + n - 1;
        e.cnt    = exp_cnt;
        e.pc_en  = (op == OP_BEQ) ? z : 1'b0;
        e.pc_src = (op == OP_BEQ);
        e.rw     = (op != OP_SW) && (op != OP_BEQ);
        e.m2r    = (op == OP_LW);
        sbq.push_back(e);
        exp_cnt = exp_cnt + 32'd1;
        opcode = op;
        zero = z;
        for (int c = 1; c <= n; c++) begin
            rel = c - fw;
            mem_ready = !(c <= fw || (rel >= 4 && rel < 4 + mw));
            if (rel == 4 && mw > 0) begin
                #1;
                check("wait_mem_req", {31'd0, bus_a.mem_req}, 32'd1);
                check("wait_iord", {31'd0, bus_a.iord}, 32'd1);
                check("wait_we", {31'd0, bus_a.mem_we},
                      {31'd0, (op == OP_SW)});
            end
            @(negedge clk);
            scyc++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        rst = 1'b1;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mem_req", {31'd0, bus_a.mem_req}, 32'd0);
        check("rst_ir_write", {31'd0, a_ir}, 32'd0);
        check("rst_pc_en", {31'd0, a_pc_en}, 32'd0);
        check("rst_retire", {31'd0, a_retire}, 32'd0);
        check("rst_instret", a_instret, 32'd0);
        check("rst_err", {30'd0, a_err}, 32'd0);

        rst = 1'b0;
        scyc = 1;
        #1;
        check("fetch_mem_req", {31'd0, bus_a.mem_req}, 32'd1);
        check("fetch_ir_write", {31'd0, a_ir}, 32'd1);
        check("fetch_pc_en", {31'd0, a_pc_en}, 32'd1);
        check("fetch_srcb", {30'd0, a_srcb}, 32'd1);
        check("fetch_halted", {31'd0, a_halted}, 32'd0);

        instr(OP_I, 1'b0, 0, 0);
        instr(OP_R, 1'b0, 0, 0);
        instr(OP_LW, 1'b0, 0, 0);
        instr(OP_SW, 1'b0, 0, 0);
        instr(OP_BEQ, 1'b1, 0, 0);
        #1;
        check("instret_after_5", a_instret, 32'd5);

        instr(OP_BEQ, 1'b0, 0, 0);
        #1;
        check("after_beq_req", {31'd0, bus_a.mem_req}, 32'd1);
        check("after_beq_iord", {31'd0, bus_a.iord}, 32'd0);

        instr(OP_LW, 1'b0, 0, 3);
        instr(OP_I, 1'b0, 14, 0);
        for (int k = 0; k < 9; k++)
            instr((k % 2 == 0) ? OP_I : OP_BEQ, 1'b1, 0, 0);
        #1;
        check("instret_17", a_instret, 32'd17);
        check("instret4_wrap", {28'd0, b_instret}, 32'd1);
        check("sb_drained", sbq.size(), 32'd0);

        opcode = 7'b1111111;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("illegal_halted", {31'd0, a_halted}, 32'd1);
        check("illegal_err", {30'd0, a_err}, 32'd1);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (bus_a.mem_req || a_retire) bad = 1'b1;
        end
        check("halt_quiet", {31'd0, bad}, 32'd0);
        check("halt_err_held", {30'd0, a_err}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_clr_halted", {31'd0, a_halted}, 32'd0);
        check("rst_clr_err", {30'd0, a_err}, 32'd0);
        check("rst_clr_req", {31'd0, bus_a.mem_req}, 32'd0);

        @(negedge clk);
        opcode = OP_I;
        mem_ready = 1'b0;
        rst = 1'b0;
        repeat (14) @(negedge clk);
        #1;
        check("to_not_yet", {31'd0, a_halted}, 32'd0);
        check("to_req_held", {31'd0, bus_a.mem_req}, 32'd1);
        @(negedge clk);
        #1;
        check("to_halted", {31'd0, a_halted}, 32'd1);
        check("to_err", {30'd0, a_err}, 32'd2);
        check("to_no_req", {31'd0, bus_a.mem_req}, 32'd0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        opcode = OP_SW;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("sw_wait_req", {31'd0, bus_a.mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_req", {31'd0, bus_a.mem_req}, 32'd0);
        check("abort_retire", {31'd0, a_retire}, 32'd0);
        check("abort_instret", a_instret, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32 subset datapath (R-type add/sub/and/or/slt, addi, lw, sw, beq). It replaces single-cycle control with a Moore FSM so the ALU and one unified instruction/data memory are reused across cycles. Memory accesses use a req/ready handshake with a timeout. Retired instructions are counted.

Parameters:
CNT_W, 32, width of retired-instruction counter
TIMEOUT, 15, max cycles waiting on mem_ready before halting; 0 disables timeout

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
opcode  in  7  inst[6:0] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  1=write, 0=read; valid with mem_req
iord  out  1  memory address: 0=PC, 1=ALUOut
ir_write  out  1  latch instruction register and old-PC register
pc_en  out  1  load PC this cycle
pc_src  out  1  PC source: 0=ALU result, 1=ALUOut
alusrc_a  out  2  0=PC, 1=old PC, 2=rs1 data
alusrc_b  out  2  0=rs2 data, 1=constant 4, 2=ImmGen
aluop  out  2  0=add, 1=sub, 2=decode funct
reg_write  out  1  register-file write enable
memtoreg  out  1  writeback source: 0=ALUOut, 1=MDR
halted  out  1  FSM in HALT
err  out  2  0=none, 1=illegal opcode, 2=memory timeout
instret  out  CNT_W  retired-instruction count
retire  out  1  one-cycle pulse in final cycle of each instruction

Behaviour:
- Reset (async, rst=1): state=FETCH, instret=0, err=0, wait counter=0. All enables (mem_req, ir_write, pc_en, reg_write, retire) forced 0 while rst=1. Async assert; release takes effect at the next edge.
- Outputs are Moore (state-decoded). Exception: pc_en in BRANCH = zero. Unlisted outputs in a state are 0.
- FETCH: mem_req=1, we=0, iord=0, A=PC, B=4, aluop=0, pc_src=0. ir_write=pc_en=mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: A=old PC, B=ImmGen, aluop=0 (branch target latched in ALUOut).
  - opcode 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - any other -> HALT with err=1
- EXEC_R: A=rs1, B=rs2, aluop=2 -> WB_ALU.
- EXEC_I: A=rs1, B=ImmGen, aluop=0 -> WB_ALU.
- WB_ALU: reg_write=1, memtoreg=0, retire=1 -> FETCH.
- MEM_ADDR: A=rs1, B=ImmGen, aluop=0. Next state: MEM_RD if opcode=0000011, else MEM_WR.
- MEM_RD: mem_req=1, we=0, iord=1. Holds until mem_ready, then -> WB_MEM.
- WB_MEM: reg_write=1, memtoreg=1, retire=1 -> FETCH.
- MEM_WR: mem_req=1, we=1, iord=1. Holds until mem_ready; retire=mem_ready. On ready -> FETCH.
- BRANCH: A=rs1, B=rs2, aluop=1, pc_src=1, pc_en=zero, retire=1 -> FETCH.
- Latency with mem_ready=1 immediately:
  - R/addi: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq: 3 cycles
  - each wait cycle adds 1.
- Timeout: wait counter increments each cycle mem_req=1 and mem_ready=0, and clears when mem_ready=1 or on leaving the state. If TIMEOUT!=0 and the counter reaches TIMEOUT with ready still 0, next state is HALT with err=2. Within the limit, ready arriving on wait cycle TIMEOUT-1 is still accepted.
- HALT: all enables 0, halted=1, err held. Only rst exits.
- instret increments by 1 on every cycle with retire=1 and wraps to 0 after all-ones. No saturation.
- The opcode input is sampled only in DECODE and MEM_ADDR, so the datapath must hold the IR stable.
- rst asserted mid-access aborts the access immediately. mem_req drops asynchronously and no write completes.

Test Plan:
- Reset with rst=1 for 3 cycles, then release, mem_ready=1 -> first cycle is FETCH with mem_req=1, ir_write=1, pc_en=1; instret=0, err=0.
- Execute sequence addi, add (0110011), lw, sw, beq (zero=1) with ready=1 -> retire pulses at cycles 4, 8, 13, 17, 20; instret=5; beq cycle shows pc_en=1, pc_src=1.
- beq with zero=0 -> pc_en=0 in BRANCH; retire=1; next state FETCH.
- lw with mem_ready held low 3 cycles in MEM_RD -> mem_req stays 1, iord=1; WB_MEM occurs 1 cycle after ready; total 8 cycles.
- opcode 1111111 in DECODE -> halted=1, err=1; no further mem_req for 20 cycles; rst clears it.
- mem_ready held 0 in FETCH with TIMEOUT=15 -> HALT with err=2 after 15 wait cycles. CNT_W=4 and 17 retirements -> instret=1 (wrap).
